// File: rtl/vga_pkg.sv
// vga_pkg: raster timing constants, colour-bar table and pixel types
// shared by the vga_scanout block and its sub-modules.
package vga_pkg;

  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = 640 + H_FP + H_SYNC + H_BP;

  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = 480 + V_FP + V_SYNC + V_BP;

  localparam int BAR_W  = 80;
  localparam int N_BARS = 8;

  // One flag per channel: set means that channel is driven all-ones.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t BARS [N_BARS] = '{
    3'b111,
    3'b110,
    3'b011,
    3'b010,
    3'b101,
    3'b100,
    3'b001,
    3'b000
  };

  function automatic rgb_t bar_colour(
    input logic [9:0] x
  );
    logic [9:0] idx;
    idx = x / 10'(BAR_W);
    return BARS[idx[2:0]];
  endfunction

endpackage

// File: rtl/vga_scanout_sync_delay.sv
// sync_delay: clock-enabled shift register of STAGES words with a
// programmable reset word; STAGES of zero collapses to a wire.
module sync_delay #(
  parameter int               WIDTH     = 3,
  parameter int               STAGES    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (STAGES == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst_n, en};
      assign q = d;
    end else begin : g_sr
      logic [WIDTH-1:0] sr [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < STAGES; i++) begin
            sr[i] <= RESET_VAL;
          end
        end else if (en) begin
          sr[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            sr[i] <= sr[i-1];
          end
        end
      end

      assign q = sr[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 raster generator and VGA pin driver for the
// layer chain. Define TEST_PATTERN_EN to add selectable colour bars.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int HWIDTH   = 12,
  parameter int VWIDTH   = 12,
  parameter int CLK_DIV  = 4,
  parameter int PIPE_LAT = 1,
  parameter int HSIZE    = 640,
  parameter int VSIZE    = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [HWIDTH-1:0] hdata,
  output logic [VWIDTH-1:0] vdata,
  input  logic [DEPTH-1:0]  R_in,
  input  logic [DEPTH-1:0]  G_in,
  input  logic [DEPTH-1:0]  B_in,
  input  logic              pattern_sel,
  output logic [DEPTH-1:0]  vga_r,
  output logic [DEPTH-1:0]  vga_g,
  output logic [DEPTH-1:0]  vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_start
);

  localparam int HT = HSIZE + H_FP + H_SYNC + H_BP;
  localparam int VT = VSIZE + V_FP + V_SYNC + V_BP;
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [HWIDTH-1:0] H_LAST = HWIDTH'(HT - 1);
  localparam logic [HWIDTH-1:0] H_VIS  = HWIDTH'(HSIZE);
  localparam logic [HWIDTH-1:0] HS_LO  = HWIDTH'(HSIZE + H_FP);
  localparam logic [HWIDTH-1:0] HS_HI  = HWIDTH'(HSIZE + H_FP + H_SYNC);

  localparam logic [VWIDTH-1:0] V_LAST = VWIDTH'(VT - 1);
  localparam logic [VWIDTH-1:0] V_VIS  = VWIDTH'(VSIZE);
  localparam logic [VWIDTH-1:0] VS_LO  = VWIDTH'(VSIZE + V_FP);
  localparam logic [VWIDTH-1:0] VS_HI  = VWIDTH'(VSIZE + V_FP + V_SYNC);

`ifdef TEST_PATTERN_EN
  localparam int SW = 3 + HWIDTH;
  localparam logic [SW-1:0] SD_RST = {{HWIDTH{1'b0}}, 3'b111};
`else
  localparam int SW = 3;
  localparam logic [SW-1:0] SD_RST = 3'b111;
`endif

  logic [DW-1:0]     div;
  logic              pix_tick;
  logic [HWIDTH-1:0] hcount;
  logic [VWIDTH-1:0] vcount;
  logic              h_last;
  logic              v_last;
  logic              hs_raw;
  logic              vs_raw;
  logic              blank_raw;
  logic              hs_d;
  logic              vs_d;
  logic              blank_d;
  logic [SW-1:0]     sd_in;
  logic [SW-1:0]     sd_out;
  logic [DEPTH-1:0]  r_px;
  logic [DEPTH-1:0]  g_px;
  logic [DEPTH-1:0]  b_px;

  assign pix_tick = (div == DIV_LAST);
  assign h_last   = (hcount == H_LAST);
  assign v_last   = (vcount == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (pix_tick) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_tick) begin
      if (h_last) begin
        hcount <= '0;
        vcount <= v_last ? '0 : vcount + VWIDTH'(1);
      end else begin
        hcount <= hcount + HWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && h_last && v_last;
    end
  end

  assign hdata = hcount;
  assign vdata = vcount;

  assign hs_raw    = !(hcount >= HS_LO && hcount < HS_HI);
  assign vs_raw    = !(vcount >= VS_LO && vcount < VS_HI);
  assign blank_raw = (hcount >= H_VIS) || (vcount >= V_VIS);

`ifdef TEST_PATTERN_EN
  assign sd_in = {hcount, hs_raw, vs_raw, blank_raw};
`else
  assign sd_in = {hs_raw, vs_raw, blank_raw};
`endif

  // The pin registers are the last alignment stage, so the line
  // itself carries one stage fewer than the total latency.
  sync_delay #(
    .WIDTH     (SW),
    .STAGES    (PIPE_LAT - 1),
    .RESET_VAL (SD_RST)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_tick),
    .d     (sd_in),
    .q     (sd_out)
  );

  assign {hs_d, vs_d, blank_d} = sd_out[2:0];

`ifdef TEST_PATTERN_EN
  logic [HWIDTH-1:0] hcount_d;
  rgb_t              bar;
  logic              unused_hcount_hi;

  assign hcount_d         = sd_out[SW-1:3];
  assign bar              = bar_colour(hcount_d[9:0]);
  assign unused_hcount_hi = ^hcount_d[HWIDTH-1:10];
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
`endif

  always_comb begin
    r_px = R_in;
    g_px = G_in;
    b_px = B_in;
`ifdef TEST_PATTERN_EN
    if (pattern_sel) begin
      r_px = {DEPTH{bar.r}};
      g_px = {DEPTH{bar.g}};
      b_px = {DEPTH{bar.b}};
    end
`endif
    if (blank_d) begin
      r_px = '0;
      g_px = '0;
      b_px = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else if (pix_tick) begin
      vga_r  <= r_px;
      vga_g  <= g_px;
      vga_b  <= b_px;
      vga_hs <= hs_d;
      vga_vs <= vs_d;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: randomized self-checking bench for vga_scanout using a
// raster-position model derived from elapsed clocks since reset release.
module tb_vga_scanout;

  localparam int DEPTH    = 4;
  localparam int HWIDTH   = 12;
  localparam int VWIDTH   = 12;
  localparam int CLK_DIV  = 3;
  localparam int PIPE_LAT = 2;
  localparam int HSIZE    = 160;
  localparam int VSIZE    = 2;

  localparam int HT = HSIZE + 16 + 96 + 48;
  localparam int VT = VSIZE + 10 + 2 + 33;
  localparam int FT = HT * VT;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [HWIDTH-1:0] hdata;
  logic [VWIDTH-1:0] vdata;
  logic [DEPTH-1:0]  R_in = '0;
  logic [DEPTH-1:0]  G_in = '0;
  logic [DEPTH-1:0]  B_in = '0;
  logic              pattern_sel = 1'b0;
  logic [DEPTH-1:0]  vga_r;
  logic [DEPTH-1:0]  vga_g;
  logic [DEPTH-1:0]  vga_b;
  logic              vga_hs;
  logic              vga_vs;
  logic              frame_start;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int seed   = 0;
  bit const_mode = 1'b0;

  vga_scanout #(
    .DEPTH    (DEPTH),
    .HWIDTH   (HWIDTH),
    .VWIDTH   (VWIDTH),
    .CLK_DIV  (CLK_DIV),
    .PIPE_LAT (PIPE_LAT),
    .HSIZE    (HSIZE),
    .VSIZE    (VSIZE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hdata       (hdata),
    .vdata       (vdata),
    .R_in        (R_in),
    .G_in        (G_in),
    .B_in        (B_in),
    .pattern_sel (pattern_sel),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] colour(int h, int v);
    if (const_mode) return 12'hFFF;
    return 12'((h * 7) ^ (v * 13) ^ seed);
  endfunction

  function automatic logic [11:0] bar_rgb(int h);
    case (h / 80)
      0:       return 12'hFFF;
      1:       return 12'hFF0;
      2:       return 12'h0FF;
      3:       return 12'h0F0;
      4:       return 12'hF0F;
      5:       return 12'hF00;
      6:       return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // Zero-latency layer chain: colour follows the issued coordinates.
  always @(negedge clk) begin
    {R_in, G_in, B_in} <= colour(int'(hdata), int'(vdata));
  end

  function automatic logic [23:0] exp_raster(int c);
    int p;
    p = (c / CLK_DIV) % FT;
    return {12'(p % HT), 12'(p / HT)};
  endfunction

  function automatic logic exp_fs(int c);
    int n;
    n = c / CLK_DIV;
    return (c % CLK_DIV == 0) && (n > 0) && (n % FT == 0);
  endfunction

  function automatic logic [13:0] exp_pins(int c);
    int n, ps, pc, h, v;
    logic [11:0] rgb;
    logic hs, vs;
    n = c / CLK_DIV;
    if (n < PIPE_LAT) return {12'h000, 2'b11};
    ps = (n - PIPE_LAT) % FT;
    h  = ps % HT;
    v  = ps / HT;
    pc = (n - 1) % FT;
    hs = !(h >= HSIZE + 16 && h < HSIZE + 16 + 96);
    vs = !(v >= VSIZE + 10 && v < VSIZE + 12);
    rgb = colour(pc % HT, pc / HT);
`ifdef TEST_PATTERN_EN
    if (pattern_sel) rgb = bar_rgb(h);
`endif
    if (h >= HSIZE || v >= VSIZE) rgb = 12'h000;
    return {rgb, hs, vs};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    seed = int'($urandom_range(0, 4095));
    repeat (10) @(negedge clk);
    total++;
    if ({hdata, vdata} !== 24'h0) begin
      $display("FAIL reset_raster got %h want 0", {hdata, vdata});
    end else passed++;
    total++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      $display("FAIL reset_rgb got %h want 000", {vga_r, vga_g, vga_b});
    end else passed++;
    total++;
    if ({vga_hs, vga_vs} !== 2'b11) begin
      $display("FAIL reset_sync got %b want 11", {vga_hs, vga_vs});
    end else passed++;
    total++;
    if (frame_start !== 1'b0) begin
      $display("FAIL reset_fs got %b want 0", frame_start);
    end else passed++;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_startup();
    logic [11:0] want;
    for (int i = 1; i <= CLK_DIV; i++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      want = (i == CLK_DIV) ? 12'd1 : 12'd0;
      total++;
      if (hdata !== want) begin
        $display("FAIL startup_hdata clk %0d got %0d want %0d", i, hdata, want);
      end else passed++;
    end
  endtask

  task automatic test_frame();
    int hs_f1 = -1, hs_f2 = -1, hs_r1 = -1;
    int vs_f = -1, vs_r = -1, fs_first = -1, fs_cnt = 0;
    logic p_hs = 1'b1, p_vs = 1'b1;
    while (cyc < FT * CLK_DIV + 3 * HT * CLK_DIV) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      total++;
      if ({hdata, vdata} !== exp_raster(cyc)) begin
        $display("FAIL frame_raster clk %0d got %h want %h",
                 cyc, {hdata, vdata}, exp_raster(cyc));
      end else passed++;
      total++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== exp_pins(cyc)) begin
        $display("FAIL frame_pins clk %0d got %h want %h", cyc,
                 {vga_r, vga_g, vga_b, vga_hs, vga_vs}, exp_pins(cyc));
      end else passed++;
      total++;
      if (frame_start !== exp_fs(cyc)) begin
        $display("FAIL frame_fs clk %0d got %b want %b",
                 cyc, frame_start, exp_fs(cyc));
      end else passed++;
      if (p_hs && !vga_hs) begin
        if (hs_f1 < 0) hs_f1 = cyc;
        else if (hs_f2 < 0) hs_f2 = cyc;
      end
      if (!p_hs && vga_hs && hs_r1 < 0) hs_r1 = cyc;
      if (p_vs && !vga_vs && vs_f < 0) vs_f = cyc;
      if (!p_vs && vga_vs && vs_r < 0) vs_r = cyc;
      if (frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = cyc;
      end
      p_hs = vga_hs;
      p_vs = vga_vs;
    end
    total++;
    if (hs_f1 != (HSIZE + 16 + PIPE_LAT) * CLK_DIV) begin
      $display("FAIL hs_fall got %0d want %0d",
               hs_f1, (HSIZE + 16 + PIPE_LAT) * CLK_DIV);
    end else passed++;
    total++;
    if (hs_r1 - hs_f1 != 96 * CLK_DIV) begin
      $display("FAIL hs_width got %0d want %0d", hs_r1 - hs_f1, 96 * CLK_DIV);
    end else passed++;
    total++;
    if (hs_f2 - hs_f1 != HT * CLK_DIV) begin
      $display("FAIL line_period got %0d want %0d", hs_f2 - hs_f1, HT * CLK_DIV);
    end else passed++;
    total++;
    if (vs_r - vs_f != 2 * HT * CLK_DIV || vs_f < 0) begin
      $display("FAIL vs_width got %0d want %0d", vs_r - vs_f, 2 * HT * CLK_DIV);
    end else passed++;
    total++;
    if (fs_first != FT * CLK_DIV || fs_cnt != 1) begin
      $display("FAIL frame_start at %0d x%0d want %0d x1",
               fs_first, fs_cnt, FT * CLK_DIV);
    end else passed++;
  endtask

  task automatic test_blanking();
    int lit = 0;
    rst_n = 1'b0;
    const_mode = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 3 * HT * CLK_DIV) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      total++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== exp_pins(cyc)) begin
        $display("FAIL blank_pins clk %0d got %h want %h", cyc,
                 {vga_r, vga_g, vga_b, vga_hs, vga_vs}, exp_pins(cyc));
      end else passed++;
      if ({vga_r, vga_g, vga_b} === 12'hFFF) lit++;
    end
    total++;
    if (lit != VSIZE * HSIZE * CLK_DIV) begin
      $display("FAIL blank_lit got %0d want %0d", lit, VSIZE * HSIZE * CLK_DIV);
    end else passed++;
    const_mode = 1'b0;
  endtask

  task automatic test_async_reset();
    int guard = 0;
    int fs_seen = 0;
    while (hdata !== 12'd300 && guard < 2 * HT * CLK_DIV) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    total++;
    if (hdata !== 12'd300) begin
      $display("FAIL async_wait got %0d want 300", hdata);
    end else passed++;
    #2;
    rst_n = 1'b0;
    seed = int'($urandom_range(0, 4095));
    #1;
    total++;
    if ({hdata, vdata} !== 24'h0) begin
      $display("FAIL async_raster got %h want 0", {hdata, vdata});
    end else passed++;
    total++;
    if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start} !== 15'b110) begin
      $display("FAIL async_pins got %h want 0006",
               {vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start});
    end else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 2 * HT * CLK_DIV) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      total++;
      if ({hdata, vdata} !== exp_raster(cyc)) begin
        $display("FAIL restart_raster clk %0d got %h want %h",
                 cyc, {hdata, vdata}, exp_raster(cyc));
      end else passed++;
      total++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== exp_pins(cyc)) begin
        $display("FAIL restart_pins clk %0d got %h want %h", cyc,
                 {vga_r, vga_g, vga_b, vga_hs, vga_vs}, exp_pins(cyc));
      end else passed++;
      if (frame_start === 1'b1) fs_seen++;
    end
    total++;
    if (fs_seen != 0) begin
      $display("FAIL restart_fs got %0d pulses want 0", fs_seen);
    end else passed++;
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    rst_n = 1'b0;
    pattern_sel = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < HT * CLK_DIV) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      total++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== exp_pins(cyc)) begin
        $display("FAIL pattern_pins clk %0d got %h want %h", cyc,
                 {vga_r, vga_g, vga_b, vga_hs, vga_vs}, exp_pins(cyc));
      end else passed++;
      if (cyc == (85 + PIPE_LAT) * CLK_DIV) begin
        total++;
        if ({vga_r, vga_g, vga_b} !== 12'hFF0) begin
          $display("FAIL pattern_x85 got %h want ff0", {vga_r, vga_g, vga_b});
        end else passed++;
      end
    end
    pattern_sel = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_startup();
    test_frame();
    test_blanking();
    test_async_reset();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
